// File: rtl/pad_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// pad_input_conditioner_if
//
// Purpose: bundles the pad-side input and the conditioned core-side outputs
// of pad_input_conditioner into one interface.
//
// Signals:
//   I         raw pad level from the input buffer (asynchronous to CLK)
//   O         debounced, synchronised level
//   RISE      one-cycle pulse when O goes 0->1
//   FALL      one-cycle pulse when O goes 1->0
//   CHANGING  high while a candidate level change is being qualified
//
// Modports:
//   master  the environment: drives I, observes the conditioned outputs
//   slave   the conditioner itself: consumes I, drives the outputs
// ---------------------------------------------------------------------------
interface pad_input_conditioner_if;
    logic I;
    logic O;
    logic RISE;
    logic FALL;
    logic CHANGING;

    modport master (
        output I,
        input  O,
        input  RISE,
        input  FALL,
        input  CHANGING
    );

    modport slave (
        input  I,
        output O,
        output RISE,
        output FALL,
        output CHANGING
    );
endinterface

// File: rtl/pad_input_conditioner.sv
// ---------------------------------------------------------------------------
// pad_input_conditioner
//
// Purpose: takes the raw, possibly bouncing level from an input pad buffer,
// synchronises it into the CLK domain through a plain flop chain, and only
// lets the output O follow once the synchronised level has disagreed with O
// for DEBOUNCE_CYCLES consecutive cycles. Registered single-cycle RISE/FALL
// strobes accompany every change of O.
//
// Ports:
//   CLK          system clock, all state updates on the rising edge
//   RST          synchronous reset, active-high, highest priority
//   pad.I        raw pad level (asynchronous)
//   pad.O        debounced, synchronised level
//   pad.RISE     one-cycle pulse in the cycle O goes 0->1
//   pad.FALL     one-cycle pulse in the cycle O goes 1->0
//   pad.CHANGING high while a candidate change is being qualified
//
// Parameters:
//   SYNC_STAGES      synchroniser depth, 2..4
//   DEBOUNCE_CYCLES  qualification length in CLK cycles, 1..65535
//   RESET_LEVEL      level loaded into the synchroniser and O on reset
//
// Latency: a new held level first sampled on edge 0 reaches O (with its
// strobe) on edge SYNC_STAGES + DEBOUNCE_CYCLES - 1.
// ---------------------------------------------------------------------------
module pad_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST,
    pad_input_conditioner_if.slave pad
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which the next disagreeing cycle completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   o_q, o_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   changing_q, changing_d;

    assign s = sync_q[SYNC_STAGES-1];

    // ---- synchroniser: plain shift chain, only sync_q[0] may go metastable
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad.I};
        end
    end

    // ---- debounce state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_STABLE;
            count_q    <= '0;
            o_q        <= RESET_LEVEL;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            changing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            o_q        <= o_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            changing_q <= changing_d;
        end
    end

    // ---- next-state logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        o_d     = o_q;
        case (state_q)
            ST_STABLE: begin
                if (s == o_q) begin
                    count_d = '0;
                end else if (DEBOUNCE_CYCLES == 1) begin
                    // Single-cycle qualification: no PENDING visit needed.
                    o_d = s;
                end else begin
                    state_d = ST_PENDING;
                    count_d = CNT_W'(1);
                end
            end
            ST_PENDING: begin
                if (s == o_q) begin
                    // Glitch back to the old level: restart from zero later.
                    state_d = ST_STABLE;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    o_d     = s;
                    state_d = ST_STABLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                count_d = '0;
            end
        endcase
    end

    // ---- output logic: strobes and CHANGING are registered versions of
    // what the next state will be, so they line up with O
    always_comb begin
        rise_d     = o_d & ~o_q;
        fall_d     = ~o_d & o_q;
        changing_d = (state_d == ST_PENDING);
    end

    assign pad.O        = o_q;
    assign pad.RISE     = rise_q;
    assign pad.FALL     = fall_q;
    assign pad.CHANGING = changing_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_pad_input_conditioner
//
// Table-driven bench for pad_input_conditioner. dut_a uses SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_LEVEL=0 and is driven from a vector table, one
// record per clock edge. dut_b uses DEBOUNCE_CYCLES=1 and is exercised by a
// hand-written latency sequence.
// ---------------------------------------------------------------------------
module tb_pad_input_conditioner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    pad_input_conditioner_if ifa ();
    pad_input_conditioner_if ifb ();

    pad_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RESET_LEVEL    (1'b0)
    ) dut_a (
        .CLK(clk),
        .RST(rst_a),
        .pad(ifa)
    );

    pad_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(1),
        .RESET_LEVEL    (1'b0)
    ) dut_b (
        .CLK(clk),
        .RST(rst_b),
        .pad(ifb)
    );

    typedef struct {
        bit rst;
        bit i;
        bit o;
        bit rise;
        bit fall;
        bit chg;
    } vec_t;

    vec_t vecs[$];
    int   n_total  = 0;
    int   n_passed = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit i, input bit o, input bit ri, input bit fa, input bit ch);
        vec_t v;
        v.rst  = r;
        v.i    = i;
        v.o    = o;
        v.rise = ri;
        v.fall = fa;
        v.chg  = ch;
        vecs.push_back(v);
    endtask

    initial begin
        int  found;
        int  chg_seen;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.I = 1'b0;
        ifb.I = 1'b0;

        //   rst i   O R F C   (outputs expected right after the edge)
        // reset held 3 cycles with I=1
        add(1, 1,  0, 0, 0, 0);
        add(1, 1,  0, 0, 0, 0);
        add(1, 1,  0, 0, 0, 0);
        // release with I=1 held: edges 0..6
        add(0, 1,  0, 0, 0, 0);
        add(0, 1,  0, 0, 0, 0);
        add(0, 1,  0, 0, 0, 1);
        add(0, 1,  0, 0, 0, 1);
        add(0, 1,  0, 0, 0, 1);
        add(0, 1,  1, 1, 0, 0);
        add(0, 1,  1, 0, 0, 0);
        // clean fall 1->0: edges 0..6
        add(0, 0,  1, 0, 0, 0);
        add(0, 0,  1, 0, 0, 0);
        add(0, 0,  1, 0, 0, 1);
        add(0, 0,  1, 0, 0, 1);
        add(0, 0,  1, 0, 0, 1);
        add(0, 0,  0, 0, 1, 0);
        add(0, 0,  0, 0, 0, 0);
        // bounce: high 3, low 1, high 2, then low
        add(0, 1,  0, 0, 0, 0);
        add(0, 1,  0, 0, 0, 0);
        add(0, 1,  0, 0, 0, 1);
        add(0, 0,  0, 0, 0, 1);
        add(0, 1,  0, 0, 0, 1);
        add(0, 1,  0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 1);
        add(0, 0,  0, 0, 0, 1);
        add(0, 0,  0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0);
        // clean rise started, reset asserted at count=2
        add(0, 1,  0, 0, 0, 0);
        add(0, 1,  0, 0, 0, 0);
        add(0, 1,  0, 0, 0, 1);
        add(0, 1,  0, 0, 0, 1);
        add(1, 1,  0, 0, 0, 0);
        add(1, 1,  0, 0, 0, 0);
        // release with I=0: stays quiet, no strobe
        add(0, 0,  0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0);

        foreach (vecs[k]) begin
            rst_a = vecs[k].rst;
            ifa.I = vecs[k].i;
            @(posedge clk);
            #1;
            chk("O",        k, int'(ifa.O),        int'(vecs[k].o));
            chk("RISE",     k, int'(ifa.RISE),     int'(vecs[k].rise));
            chk("FALL",     k, int'(ifa.FALL),     int'(vecs[k].fall));
            chk("CHANGING", k, int'(ifa.CHANGING), int'(vecs[k].chg));
        end

        // DEBOUNCE_CYCLES=1: reset with I=1, then measure latency of O
        ifb.I = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("B reset O", 0, int'(ifb.O), 0);
        rst_b    = 1'b0;
        found    = -1;
        chg_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (ifb.CHANGING) chg_seen = 1;
            if (ifb.O == 1'b1) begin
                found = k;
                break;
            end
        end
        chk("B rise latency", 0, found, 2);
        chk("B RISE at change", 0, int'(ifb.RISE), 1);
        chk("B FALL at rise", 0, int'(ifb.FALL), 0);
        chk("B CHANGING seen", 0, chg_seen, 0);
        @(posedge clk);
        #1;
        chk("B RISE cleared", 0, int'(ifb.RISE), 0);
        chk("B O held", 0, int'(ifb.O), 1);

        // DEBOUNCE_CYCLES=1: held fall
        ifb.I = 1'b0;
        found = -1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (ifb.O == 1'b0) begin
                found = k;
                break;
            end
        end
        chk("B fall latency", 1, found, 2);
        chk("B FALL at change", 1, int'(ifb.FALL), 1);
        chk("B RISE at fall", 1, int'(ifb.RISE), 0);
        @(posedge clk);
        #1;
        chk("B FALL cleared", 1, int'(ifb.FALL), 0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
